reg_sum_arb: RTL and testbench
==============================

// Module: reg_sum_arb
// PURPOSE
//   Shares one pipelined 4-operand adder among N_REQ requesters. Round-robin
//   arbiter grants one request per cycle; operands enter a 2-stage adder
//   tree tagged with the requester ID; the result returns with that ID.
//   Sits between the requesting blocks and the summation datapath.
// PARAMETERS
//   N_REQ    4   number of requesters (2..8)
//   DATA_W   8   operand and result width in bits
//   ID_W     $clog2(N_REQ)  requester-ID width (derived, do not override)
// PORTS
//   clk_i        in   1               clock, rising edge
//   rst_i        in   1               synchronous reset, active high
//   hold_i       in   1               1 = issue no new grants; pipeline drains
//   req_valid_i  in   N_REQ           per-requester request valid
//   req_x_i      in   N_REQ*4*DATA_W  operands; requester k, operand j at
//                                     [(k*4+j)*DATA_W +: DATA_W]
//   req_ready_o  out  N_REQ           one-hot grant (combinational)
//   res_valid_o  out  1               result valid, one-cycle pulse
//   res_id_o     out  ID_W            requester ID of the result
//   res_sum_o    out  DATA_W          x0+x1+x2+x3 mod 2^DATA_W
//   busy_o       out  1               any pipeline stage holds a valid entry
//   issue_cnt_o  out  16              accepted-request count, wraps at 2^16
// BEHAVIOUR
//   Reset: res_valid_o=0, res_id_o=0, res_sum_o=0, busy_o=0, issue_cnt_o=0,
//     RR pointer=0, both stage valids=0; in-flight entries are discarded.
//     A grant in the reset cycle has no effect.
//   Arbitration: search req_valid_i from pointer p upward, modulo N_REQ; the
//     first set bit k gets req_ready_o[k]=1. All zeros if hold_i=1, rst_i=1,
//     or no valid request. At most one bit set. No dependence on outputs.
//   Transfer: req_valid_i[k] & req_ready_o[k] at a rising edge. Then
//     p <= (k+1) mod N_REQ and issue_cnt_o increments. No transfer: p holds.
//   A requester keeps valid and operands stable until granted.
//   Stage 1 (transfer edge n): s1_a=x0+x1, s1_b=x2+x3 (each DATA_W bits,
//     carry dropped), s1_id=k, s1_v=1; s1_v=0 when there is no transfer.
//   Stage 2 (edge n+1): res_sum_o=s1_a+s1_b mod 2^DATA_W, res_id_o=s1_id,
//     res_valid_o=s1_v.
//   Latency: a transfer at edge n gives res_valid_o=1 for the cycle after
//     edge n+1 (2 registers). Throughput is one result per cycle; there is
//     no output backpressure.
//   res_sum_o/res_id_o keep their last values when res_valid_o=0.
//   busy_o = s1_v | res_valid_o (registered-state OR).
//   hold_i asserted mid-stream: no new grants; entries already accepted
//     complete normally. Pointer is unchanged while held.
//   Simultaneous requests from all N_REQ: grants 0,1,..,N_REQ-1,0,... on
//     consecutive cycles. A single active requester is granted every cycle.
//   Reset mid-operation: the pipeline is flushed at once, with no
//     res_valid_o pulse for entries in flight.
// TESTING
//   T1 single: req 2 valid, x={4,6,9,3} -> ready[2] same cycle;
//      res_valid_o 2 edges later, sum=22, id=2; issue_cnt_o=1.
//   T2 round-robin: all 4 requesters valid and held -> grant order 0,1,2,3,0,
//      one per cycle; ids return in the same order, back-to-back.
//   T3 wrap: x={200,100,250,10} -> sum=(300+260) mod 256=48; stage-1
//      partials also wrap (44,4).
//   T4 hold: hold_i=1 with reqs 1,3 valid for 5 cycles -> ready all zero;
//      the in-flight result still arrives. Release -> grant 1, then 3.
//   T5 reset mid-flight: accept 2 requests, assert rst_i the next cycle ->
//      no res_valid_o, busy_o=0, issue_cnt_o=0, next grant starts from 0.
//   T6 counter: 65537 transfers -> issue_cnt_o=1.

Source files
------------

// File: rtl/reg_sum_arb.sv
// reg_sum_arb: round-robin arbiter in front of a shared, two-stage
// pipelined 4-operand adder. Each accepted request goes into the adder
// tagged with the requester ID, and the sum comes back out with that ID.
//
// Handshake (requester side): requester k raises req_valid_i[k] and holds
// it, together with its operands, until it sees req_ready_o[k]. A transfer
// happens on any rising edge where req_valid_i[k] & req_ready_o[k] is true.
// req_ready_o is combinational and one-hot (or zero). It depends only on
// req_valid_i, hold_i, rst_i and the round-robin pointer, never on outputs.
// The result side has no backpressure: res_valid_o is a one-cycle pulse.
module reg_sum_arb #(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      hold_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*4*DATA_W-1:0] req_x_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      res_valid_o,
    output logic [ID_W-1:0]           res_id_o,
    output logic [DATA_W-1:0]         res_sum_o,
    output logic                      busy_o,
    output logic [15:0]               issue_cnt_o
);

    // Round-robin pointer: the first requester to consider this cycle.
    logic [ID_W-1:0]   ptr_q, ptr_d;
    // Stage 1: pairwise partial sums.
    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    // Stage 2: final result.
    logic              res_v_q, res_v_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [DATA_W-1:0] res_sum_q, res_sum_d;
    logic [15:0]       issue_cnt_q, issue_cnt_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic              xfer;
    logic [DATA_W-1:0] x0, x1, x2, x3;

    // Search upward from the pointer. Pass one covers indices >= ptr.
    // Pass two picks the lowest index overall, which is the wrap-around case.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid_i[k] && (k >= int'(ptr_q))) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(k);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid_i[k]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(k);
            end
        end
    end

    // Grant is suppressed during hold and reset. A ready bit is only ever
    // raised on a valid requester, so any grant is a transfer.
    assign xfer = grant_found && !hold_i && !rst_i;

    // One-hot ready vector from the chosen index.
    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready_o[k] = xfer && (grant_id == ID_W'(k));
        end
    end

    // Operand mux: pick the granted requester's four operands.
    always_comb begin
        x0 = '0;
        x1 = '0;
        x2 = '0;
        x3 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                x0 = req_x_i[(k*4+0)*DATA_W +: DATA_W];
                x1 = req_x_i[(k*4+1)*DATA_W +: DATA_W];
                x2 = req_x_i[(k*4+2)*DATA_W +: DATA_W];
                x3 = req_x_i[(k*4+3)*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for pointer, counter and both adder stages.
    // The result registers keep their old values on idle cycles.
    always_comb begin
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        if (xfer) begin
            ptr_d       = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        s1_v_d    = xfer;
        s1_a_d    = xfer ? x0 + x1 : s1_a_q;
        s1_b_d    = xfer ? x2 + x3 : s1_b_q;
        s1_id_d   = xfer ? grant_id : s1_id_q;
        res_v_d   = s1_v_q;
        res_sum_d = s1_v_q ? s1_a_q + s1_b_q : res_sum_q;
        res_id_d  = s1_v_q ? s1_id_q : res_id_q;
    end

    // State registers. Reset flushes the pipeline with no result pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            res_v_q     <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            s1_v_q      <= s1_v_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            res_v_q     <= res_v_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid_o = res_v_q;
    assign res_id_o    = res_id_q;
    assign res_sum_o   = res_sum_q;
    assign busy_o      = s1_v_q | res_v_q;
    assign issue_cnt_o = issue_cnt_q;

endmodule

// File: tb/tb_reg_sum_arb.sv
// Testbench for reg_sum_arb: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbiter and adder.
module tb_reg_sum_arb;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N*4*W-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [IW-1:0]  res_id;
    logic [W-1:0]   res_sum;
    logic           busy;
    logic [15:0]    issue_cnt;

    always #5 clk = ~clk;

    reg_sum_arb #(.N_REQ(N), .DATA_W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .hold_i      (hold),
        .req_valid_i (req_valid),
        .req_x_i     (req_x),
        .req_ready_o (req_ready),
        .res_valid_o (res_valid),
        .res_id_o    (res_id),
        .res_sum_o   (res_sum),
        .busy_o      (busy),
        .issue_cnt_o (issue_cnt)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted request is a transaction stamped with its accept edge.
    // It must appear on the outputs right after the following edge.
    typedef struct {
        int edge_n;
        int id;
        int sum;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr    = 0;
    int   m_cnt    = 0;
    int   cyc      = 0;
    int   last_id  = 0;
    int   last_sum = 0;
    int   g_id     = -1;   // requester granted at the most recent edge, -1 if none
    int   ops [N][4];

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr + i) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_x();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 4; j++)
                req_x[(k*4+j)*W +: W] = W'(ops[k][j]);
    endtask

    task automatic set_ops(input int k, input int a, input int b, input int c, input int d);
        ops[k][0] = a; ops[k][1] = b; ops[k][2] = c; ops[k][3] = d;
        drive_x();
    endtask

    task automatic rand_ops(input int k);
        for (int j = 0; j < 4; j++) ops[k][j] = int'($urandom_range(0, 255));
        drive_x();
    endtask

    // One clock cycle: check ready mid-cycle, advance the model at the edge,
    // then check every registered output just after the edge.
    task automatic step();
        int          g;
        logic [N-1:0] exp_rdy;
        exp_t        e;
        @(negedge clk);
        g = (rst || hold) ? -1 : model_grant(req_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        cyc++;
        g_id = -1;
        if (rst) begin
            exp_q.delete();
            m_ptr = 0; m_cnt = 0; last_id = 0; last_sum = 0;
        end else if (g >= 0) begin
            g_id     = g;
            e.edge_n = cyc;
            e.id     = g;
            e.sum    = (ops[g][0] + ops[g][1] + ops[g][2] + ops[g][3]) % 256;
            exp_q.push_back(e);
            m_ptr = (g + 1) % N;
            m_cnt = (m_cnt + 1) % 65536;
        end
        check("busy", 32'(busy), 32'(exp_q.size() > 0));
        check("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        if (exp_q.size() > 0 && exp_q[0].edge_n == cyc - 1) begin
            e = exp_q.pop_front();
            last_id = e.id; last_sum = e.sum;
            check("res_valid", 32'(res_valid), 32'd1);
        end else begin
            check("res_valid_idle", 32'(res_valid), 32'd0);
        end
        check("res_id", 32'(res_id), 32'(last_id));
        check("res_sum", 32'(res_sum), 32'(last_sum));
    endtask

    task automatic do_reset();
        rst = 1'b1; hold = 1'b0; req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_x = '0;
        for (int k = 0; k < N; k++) set_ops(k, 0, 0, 0, 0);

        // reset state
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(issue_cnt), 32'd0);

        // T1: single request from 2
        set_ops(2, 4, 6, 9, 3);
        req_valid = 4'b0100;
        step();
        check("t1_grant", 32'(g_id), 32'd2);
        req_valid = '0;
        step();
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_sum", 32'(res_sum), 32'd22);
        check("t1_id", 32'(res_id), 32'd2);
        check("t1_cnt", 32'(issue_cnt), 32'd1);
        step();

        // T2: all requesters valid, held steady
        do_reset();
        for (int k = 0; k < N; k++) set_ops(k, k, k + 1, k + 2, k + 3);
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_grant", 32'(g_id), 32'(i % N));
        end
        req_valid = '0;
        step();
        step();

        // T3: carries dropped in both stages
        do_reset();
        set_ops(0, 200, 100, 250, 10);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        check("t3_sum", 32'(res_sum), 32'd48);
        step();

        // T4: hold with one entry in flight
        do_reset();
        set_ops(0, 1, 2, 3, 4);
        set_ops(1, 10, 20, 30, 40);
        set_ops(3, 7, 7, 7, 7);
        req_valid = 4'b0001;
        step();
        hold = 1'b1;
        req_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_no_grant", 32'(req_ready), 32'd0);
        end
        check("t4_cnt", 32'(issue_cnt), 32'd1);
        hold = 1'b0;
        step();
        check("t4_grant1", 32'(g_id), 32'd1);
        req_valid = 4'b1000;
        step();
        check("t4_grant3", 32'(g_id), 32'd3);
        req_valid = '0;
        step();
        step();

        // T5: reset with two entries in flight
        do_reset();
        req_valid = '1;
        step();
        step();
        rst = 1'b1;
        step();
        check("t5_valid", 32'(res_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cnt", 32'(issue_cnt), 32'd0);
        rst = 1'b0;
        step();
        check("t5_grant0", 32'(g_id), 32'd0);
        req_valid = '0;
        step();
        step();

        // Randomized traffic with occasional hold and reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            hold = ($urandom_range(0, 7) == 0);
            step();
            for (int k = 0; k < N; k++) begin
                if (g_id == k) begin
                    req_valid[k] = ($urandom_range(0, 1) == 1);
                    rand_ops(k);
                end else if (!req_valid[k]) begin
                    req_valid[k] = ($urandom_range(0, 2) == 0);
                    rand_ops(k);
                end
            end
        end
        rst = 1'b0; hold = 1'b0; req_valid = '0;
        step();
        step();

        // T6: counter wraps after 65537 transfers
        do_reset();
        set_ops(1, 1, 1, 1, 1);
        req_valid = 4'b0010;
        for (int i = 0; i < 65537; i++) step();
        req_valid = '0;
        check("t6_cnt", 32'(issue_cnt), 32'd1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
